fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 0, SHALL be the PC value loaded on reset (`PC_WIDTH bits).
REQ-002 Parameter TIMEOUT, default 15, SHALL be the ack-wait limit in cycles, used only under FETCH_TIMEOUT_EN.
REQ-003 fc_clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 fc_rst  in  1  reset, synchronous, active-high.
REQ-005 fc_i_ce  in  1  fetch enable.
REQ-006 fc_i_stall  in  1  downstream not ready; the held instruction SHALL NOT be consumed while high.
REQ-007 fc_i_redirect  in  1  branch/jump redirect strobe.
REQ-008 fc_i_redirect_pc  in  `PC_WIDTH  redirect target.
REQ-009 fc_o_req  out  1  memory request, level; once raised it SHALL stay high until fc_i_ack, except as REQ-024 allows.
REQ-010 fc_o_addr  out  `PC_WIDTH  request address, stable while fc_o_req=1.
REQ-011 fc_i_ack  in  1  one-cycle memory acknowledge; fc_i_instr valid with it.
REQ-012 fc_i_instr  in  `IWIDTH  returned instruction word.
REQ-013 fc_o_instr  out  `IWIDTH  fetched instruction (registered).
REQ-014 fc_o_pc  out  `PC_WIDTH  address of fc_o_instr.
REQ-015 fc_o_valid  out  1  fc_o_instr/fc_o_pc hold an unconsumed instruction.
REQ-016 fc_o_timeout  out  1  one-cycle ack-timeout pulse.

Function
REQ-017 FSM states SHALL be IDLE, REQ, HOLD, FLUSH; fc_o_req=1 exactly in REQ and FLUSH.
REQ-018 An internal pc register SHALL hold the next fetch address, separate from fc_o_addr; increment SHALL be pc+4 modulo 2^`PC_WIDTH (wraps silently).
REQ-019 IDLE: when fc_i_ce=1, fc_o_addr<=pc and go to REQ; fc_i_ack in IDLE SHALL be ignored.
REQ-020 REQ on fc_i_ack without redirect: fc_o_instr<=fc_i_instr, fc_o_pc<=fc_o_addr, fc_o_valid<=1, pc<=fc_o_addr+4, go to HOLD; fc_o_valid rises the cycle after ack.
REQ-021 HOLD: while fc_i_stall=1, outputs SHALL hold; in the cycle fc_i_stall=0 the instruction is consumed: fc_o_valid<=0, then REQ (fc_o_addr<=pc) if fc_i_ce=1, else IDLE.
REQ-022 Redirect, highest priority, in any state: pc<=fc_i_redirect_pc, fc_o_valid<=0; from IDLE/HOLD go to REQ with fc_o_addr<=fc_i_redirect_pc if fc_i_ce=1, else IDLE; from REQ with same-cycle ack the returned word SHALL be discarded and the next state is REQ with fc_o_addr<=fc_i_redirect_pc; from REQ without ack go to FLUSH keeping fc_o_addr; in FLUSH stay in FLUSH with pc overwritten.
REQ-023 FLUSH: on fc_i_ack the word SHALL be discarded (fc_o_valid stays 0), then REQ with fc_o_addr<=pc if fc_i_ce=1, else IDLE.
REQ-024 fc_i_ce=0 in REQ SHALL go to FLUSH (request completes, word discarded); in HOLD it SHALL clear fc_o_valid and go to IDLE; pc SHALL be retained.
REQ-025 Ack in HOLD SHALL be ignored; at most one request SHALL be outstanding.

Reset
REQ-026 When fc_rst=1 at a rising edge: state IDLE, pc=RESET_PC, fc_o_addr=RESET_PC, fc_o_req=0, fc_o_valid=0, fc_o_instr=0, fc_o_pc=0, fc_o_timeout=0, timeout counter=0.
REQ-027 Reset SHALL override all inputs; reset mid-request abandons it, and a later stray ack lands in IDLE and is ignored.

Configuration
REQ-028 Macro FETCH_TIMEOUT_EN defined: a counter SHALL count cycles in REQ/FLUSH without ack, clear on ack or state entry; on reaching TIMEOUT, fc_o_timeout=1 for one cycle, fc_o_req=0 for that cycle, counter clears, and the request reissues the same fc_o_addr next cycle.
REQ-029 Macro undefined: no counter; fc_o_timeout SHALL be constant 0 and the controller waits indefinitely for ack.

Verification
REQ-030 Reset, ce=1, memory ack 2 cycles after req, stall=0 -> fc_o_addr 0,4,8 in order; fc_o_pc 0,4,8 with valid one cycle after each ack.
REQ-031 Stall held 5 cycles while fc_o_pc=4 -> fc_o_valid, fc_o_instr, fc_o_pc stable, fc_o_req=0; after release next request at addr 8.
REQ-032 Redirect to 0x100 while req to 8 outstanding -> FLUSH, ack word for 8 discarded (valid stays 0), next req addr 0x100, fc_o_pc=0x100.
REQ-033 Redirect to 0x40 in the same cycle as ack -> word dropped, next cycle req addr 0x40; pc=0xFFFFFFFC (32-bit) fetch -> next addr 0.
REQ-034 FETCH_TIMEOUT_EN, TIMEOUT=15, no ack -> fc_o_timeout pulse on cycle 15 of waiting, req low one cycle, reissue same addr; without macro fc_o_timeout stays 0.
REQ-035 fc_rst asserted mid-request, ack arrives 1 cycle later -> all outputs at reset values, ack ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Instruction fetch sequencer. It issues one memory request at a time, captures
// the returned word into a registered output slot, and holds that slot until
// downstream consumes it. Redirects cancel the held word or the in-flight
// request. A redirect that arrives while a request is outstanding sends the FSM
// to FLUSH, which waits for the stale ack and throws the word away.
//
// Configuration macros:
//   PC_WIDTH         address width (default 32)
//   IWIDTH           instruction width (default 32)
//   FETCH_TIMEOUT_EN when defined, an unacknowledged request is dropped for
//                    one cycle after TIMEOUT waiting cycles and then reissued.
//                    fc_o_timeout pulses during the dropped cycle.
//
// Ports:
//   fc_clk, fc_rst      clock, synchronous active-high reset
//   fc_i_ce             fetch enable
//   fc_i_stall          downstream not ready; the held word is not consumed
//   fc_i_redirect(_pc)  redirect strobe and target address
//   fc_o_req, fc_o_addr memory request (level) and its address
//   fc_i_ack, fc_i_instr one-cycle acknowledge and the returned word
//   fc_o_instr, fc_o_pc, fc_o_valid  fetched word, its address, slot occupied
//   fc_o_timeout        one-cycle ack-timeout pulse (constant 0 without macro)
// -----------------------------------------------------------------------------
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IWIDTH
`define IWIDTH 32
`endif

module fetch_controller #(
  parameter logic [`PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned          TIMEOUT  = 15   // must be >= 1
) (
  input  logic                 fc_clk,
  input  logic                 fc_rst,
  input  logic                 fc_i_ce,
  input  logic                 fc_i_stall,
  input  logic                 fc_i_redirect,
  input  logic [`PC_WIDTH-1:0] fc_i_redirect_pc,
  output logic                 fc_o_req,
  output logic [`PC_WIDTH-1:0] fc_o_addr,
  input  logic                 fc_i_ack,
  input  logic [`IWIDTH-1:0]   fc_i_instr,
  output logic [`IWIDTH-1:0]   fc_o_instr,
  output logic [`PC_WIDTH-1:0] fc_o_pc,
  output logic                 fc_o_valid,
  output logic                 fc_o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [`PC_WIDTH-1:0]   pc_q, pc_d;       // next fetch address
  logic [`PC_WIDTH-1:0]   addr_q, addr_d;   // address of the current request
  logic [`PC_WIDTH-1:0]   opc_q, opc_d;     // address of the held word
  logic [`IWIDTH-1:0]     instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   req_q, req_d;
  logic                   ack_ok;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    // NOTE: every next-state value defaults to its current value before any
    // branch, so no path through this block can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    opc_d   = opc_q;
    instr_d = instr_q;
    valid_d = valid_q;

    // An ack is only meaningful while the request line is high. The line is
    // low in IDLE/HOLD and during a timeout drop cycle.
    ack_ok = fc_i_ack && req_q;

    if (fc_i_redirect) begin
      pc_d    = fc_i_redirect_pc;
      valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (ack_ok) begin
            addr_d = fc_i_redirect_pc;   // returned word dropped, refetch now
          end else begin
            state_d = S_FLUSH;           // keep addr until the stale ack lands
          end
        end
        S_FLUSH: begin
          // A redirect without an ack keeps waiting. A redirect with an ack
          // retires the stale request here; otherwise FLUSH would wait for an
          // ack that never comes.
          if (ack_ok) begin
            if (fc_i_ce) begin
              addr_d  = fc_i_redirect_pc;
              state_d = S_REQ;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin                   // IDLE, HOLD
          if (fc_i_ce) begin
            addr_d  = fc_i_redirect_pc;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fc_i_ce) begin
            addr_d  = pc_q;
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (!fc_i_ce) begin
            // Fetch disabled: the bus request must still complete, but its
            // word is discarded. If the ack is already here, nothing is left.
            state_d = ack_ok ? S_IDLE : S_FLUSH;
          end else if (ack_ok) begin
            instr_d = fc_i_instr;
            opc_d   = addr_q;
            valid_d = 1'b1;
            pc_d    = addr_q + `PC_WIDTH'(4);  // wraps modulo 2^PC_WIDTH
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!fc_i_ce) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end else if (!fc_i_stall) begin
            valid_d = 1'b0;
            addr_d  = pc_q;
            state_d = S_REQ;
          end
        end
        S_FLUSH: begin
          if (ack_ok) begin
            if (fc_i_ce) begin
              addr_d  = pc_q;
              state_d = S_REQ;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef FETCH_TIMEOUT_EN
    // Count waiting cycles of one continuous request. Any ack, a state change
    // or the drop cycle itself restarts the count.
    cnt_d     = '0;
    timeout_d = 1'b0;
    if ((state_q == S_REQ || state_q == S_FLUSH) && state_d == state_q &&
        req_q && !ack_ok) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    req_d = (state_d == S_REQ || state_d == S_FLUSH) && !timeout_d;
`else
    req_d = (state_d == S_REQ || state_d == S_FLUSH);
`endif
  end

  always_ff @(posedge fc_clk) begin
    if (fc_rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      opc_q     <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, whatever the statement order.
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      opc_q     <= opc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      req_q     <= req_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign fc_o_req   = req_q;
  assign fc_o_addr  = addr_q;
  assign fc_o_instr = instr_q;
  assign fc_o_pc    = opc_q;
  assign fc_o_valid = valid_q;

`ifdef FETCH_TIMEOUT_EN
  assign fc_o_timeout = timeout_q;
`else
  assign fc_o_timeout = 1'b0;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

endmodule
